// File: rtl/delay_trig_pkg.sv
// Shared types and widths for the trigger-delay block.
package delay_trig_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT,
        FIRE
    } state_t;

endpackage

// File: rtl/delay_trig_edge.sv
// Rising-edge detector; the delayed copy resets high so a level held through reset is not an event.
module delay_trig_edge (
    input  logic clk,
    input  logic rst,
    input  logic trig_in,
    output logic rise_c
);

    logic trig_in_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_in_d <= 1'b1;
        end else begin
            trig_in_d <= trig_in;
        end
    end

    assign rise_c = trig_in & ~trig_in_d;

endmodule

// File: rtl/delay_trig_block.sv
// Captures a trigger event, holds it until valid is seen, then emits a delayed, fixed-width pulse.
module delay_trig_block
    import delay_trig_pkg::*;
#(
    parameter int unsigned DELAY       = 0,
    parameter int unsigned PULSE_WIDTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_in,
    input  logic valid,
    output logic trig_out,
    output logic ready
);

    // Counters run load-1 down to 0 so the loaded value equals the remaining cycle count.
    localparam logic [CNT_W-1:0] DELAY_LOAD = (DELAY > 0) ? CNT_W'(DELAY - 1) : '0;
    localparam logic [CNT_W-1:0] PW_LOAD    = CNT_W'(PULSE_WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] dly_cnt;
    logic [CNT_W-1:0] pw_cnt;
    logic             rise_c;

    delay_trig_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .trig_in (trig_in),
        .rise_c  (rise_c)
    );

    // Outputs are updated alongside the state so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            trig_out <= 1'b0;
            ready    <= 1'b1;
            dly_cnt  <= '0;
            pw_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_c) begin
                        state <= ARMED;
                        ready <= 1'b0;
                    end
                end
                ARMED: begin
                    if (valid) begin
                        if (DELAY == 0) begin
                            state    <= FIRE;
                            trig_out <= 1'b1;
                            pw_cnt   <= PW_LOAD;
                        end else begin
                            state   <= WAIT;
                            dly_cnt <= DELAY_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (dly_cnt == '0) begin
                        state    <= FIRE;
                        trig_out <= 1'b1;
                        pw_cnt   <= PW_LOAD;
                    end else begin
                        dly_cnt <= dly_cnt - CNT_W'(1);
                    end
                end
                FIRE: begin
                    if (pw_cnt == '0) begin
                        state    <= IDLE;
                        trig_out <= 1'b0;
                        ready    <= 1'b1;
                    end else begin
                        pw_cnt <= pw_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    trig_out <= 1'b0;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_trig_block.sv
// Bench for delay_trig_block: two instances (default and DELAY=5/PULSE_WIDTH=3) against a timestamp model.
module tb_delay_trig_block;

    logic clk;
    logic rst;
    logic trig_in;
    logic valid;
    logic trig_out0, ready0;
    logic trig_out1, ready1;

    int vectors;
    int miscompares;

    delay_trig_block u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .trig_in  (trig_in),
        .valid    (valid),
        .trig_out (trig_out0),
        .ready    (ready0)
    );

    delay_trig_block #(.DELAY(5), .PULSE_WIDTH(3)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .trig_in  (trig_in),
        .valid    (valid),
        .trig_out (trig_out1),
        .ready    (ready1)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Model: a captured trigger is a flag; a released one is a pulse window [lo, hi) in edge numbers.
    longint k;
    longint fire_lo [2];
    longint fire_hi [2];
    bit     armed   [2];
    bit     prev_t  [2];
    longint m_delay [2] = '{0, 5};
    longint m_pw    [2] = '{1, 3};

    int cur_step;
    int hi_cnt [2];
    int first_hi [2];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            prev_t[m]  = 1'b1;
            armed[m]   = 1'b0;
            fire_lo[m] = k;
            fire_hi[m] = k;
        end
    endtask

    task automatic model_edge(input bit ti, input bit v, input bit r);
        k++;
        if (r) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit ev;
                bit idle;
                ev        = ti && !prev_t[m];
                prev_t[m] = ti;
                idle      = !armed[m] && (k > fire_hi[m]);
                if (armed[m] && v) begin
                    armed[m]   = 1'b0;
                    fire_lo[m] = k + m_delay[m];
                    fire_hi[m] = k + m_delay[m] + m_pw[m];
                end else if (idle && ev) begin
                    armed[m] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic exp_trig(input int m);
        return (k >= fire_lo[m]) && (k < fire_hi[m]);
    endfunction

    function automatic logic exp_ready(input int m);
        return !armed[m] && (k >= fire_hi[m]);
    endfunction

    task automatic check_all();
        chk_eq("trig_out0", 32'(trig_out0), 32'(exp_trig(0)));
        chk_eq("ready0",    32'(ready0),    32'(exp_ready(0)));
        chk_eq("trig_out1", 32'(trig_out1), 32'(exp_trig(1)));
        chk_eq("ready1",    32'(ready1),    32'(exp_ready(1)));
        if (trig_out0) begin
            if (hi_cnt[0] == 0) first_hi[0] = cur_step;
            hi_cnt[0]++;
        end
        if (trig_out1) begin
            if (hi_cnt[1] == 0) first_hi[1] = cur_step;
            hi_cnt[1]++;
        end
    endtask

    task automatic clear_hits();
        for (int m = 0; m < 2; m++) begin
            hi_cnt[m]   = 0;
            first_hi[m] = -1;
        end
    endtask

    // Inputs change 1 ns after an edge; outputs are compared 1 ns after the next edge.
    task automatic step(input bit ti, input bit v, input bit r);
        trig_in = ti;
        valid   = v;
        rst     = r;
        @(posedge clk);
        model_edge(ti, v, r);
        #1;
        check_all();
    endtask

    // Asserts reset between edges and checks it acts without a clock.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        chk_eq("async_rst_trig0",  32'(trig_out0), 32'(0));
        chk_eq("async_rst_ready0", 32'(ready0),    32'(1));
        chk_eq("async_rst_trig1",  32'(trig_out1), 32'(0));
        chk_eq("async_rst_ready1", 32'(ready1),    32'(1));
        model_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bit ti_r;
        vectors     = 0;
        miscompares = 0;
        k           = 0;
        rst         = 1'b0;
        trig_in     = 1'b0;
        valid       = 1'b0;
        cur_step    = 0;
        clear_hits();

        #1 rst = 1'b1;
        #1;
        chk_eq("por_trig0",  32'(trig_out0), 32'(0));
        chk_eq("por_ready0", 32'(ready0),    32'(1));
        chk_eq("por_trig1",  32'(trig_out1), 32'(0));
        chk_eq("por_ready1", 32'(ready1),    32'(1));
        model_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Trigger at 10, ignored retrigger at 15, valid from 21 onward.
        clear_hits();
        for (int i = 0; i <= 121; i++) begin
            cur_step = i;
            step((i == 10) || (i == 15), i >= 21, 1'b0);
        end
        chk_eq("d1_pulses0", 32'(hi_cnt[0]),   32'(1));
        chk_eq("d1_first0",  32'(first_hi[0]), 32'(21));
        chk_eq("d1_pulses1", 32'(hi_cnt[1]),   32'(3));
        chk_eq("d1_first1",  32'(first_hi[1]), 32'(26));

        // Valid already high when the trigger arrives.
        clear_hits();
        for (int i = 0; i <= 15; i++) begin
            cur_step = i;
            step(i == 3, 1'b1, 1'b0);
        end
        chk_eq("d2_pulses0", 32'(hi_cnt[0]),   32'(1));
        chk_eq("d2_first0",  32'(first_hi[0]), 32'(4));
        chk_eq("d2_pulses1", 32'(hi_cnt[1]),   32'(3));
        chk_eq("d2_first1",  32'(first_hi[1]), 32'(9));

        // Reset while armed discards the pending trigger.
        clear_hits();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_eq("d3_armed_ready0", 32'(ready0), 32'(0));
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0);
        end
        chk_eq("d3_pulses0", 32'(hi_cnt[0]), 32'(0));
        chk_eq("d3_pulses1", 32'(hi_cnt[1]), 32'(0));
        chk_eq("d3_ready0",  32'(ready0),    32'(1));

        // Random traffic with occasional asynchronous resets.
        ti_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end
            if ($urandom_range(0, 3) == 0) ti_r = ~ti_r;
            step(ti_r, $urandom_range(0, 2) == 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
